prefix_subtractor_pipe: RTL and testbench

//  Pipelined Kogge-Stone subtractor computing A - B as A + ~B + 1 in the integer ALU datapath.

---
 rtl/prefix_subtractor_pipe.sv | 136 +++++++++++++
 tb/tb_prefix_subtractor_pipe.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prefix_subtractor_pipe.sv
// Pipelined Kogge-Stone subtractor: A - B as A + ~B + 1 with a registered setup stage,
// one register per prefix level and a registered sum/flag stage behind a valid/ready handshake.
`ifndef LEN_DATA
`define LEN_DATA 32
`endif

module prefix_subtractor_pipe #(
   parameter int WIDTH = `LEN_DATA,
   parameter int LOG2W = $clog2(WIDTH),
   parameter int TAG_W = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_diff,
   output logic             out_borrow,
   output logic             out_ovf,
   output logic             out_zero,
   output logic [TAG_W-1:0] out_tag
);

   // Index 0 is the setup stage, index k holds the result of prefix level k.
   logic [LOG2W:0][WIDTH-1:0]   g_q, g_d;
   logic [LOG2W-1:0][WIDTH-1:0] p_q, p_d;
   logic [LOG2W:0][WIDTH-1:0]   x_q, x_d;
   logic [LOG2W:0]              v_q, v_d;
   logic [LOG2W:0]              sa_q, sa_d;
   logic [LOG2W:0]              sb_q, sb_d;
   logic [LOG2W:0][TAG_W-1:0]   tag_q, tag_d;

   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] diff_q, diff_d;
   logic             borrow_q, borrow_d;
   logic             ovf_q, ovf_d;
   logic             zero_q, zero_d;
   logic [TAG_W-1:0] otag_q, otag_d;

   logic en;

   always_comb begin
      en          = ~out_valid_q | out_ready;
      g_d         = g_q;
      p_d         = p_q;
      x_d         = x_q;
      v_d         = v_q;
      sa_d        = sa_q;
      sb_d        = sb_q;
      tag_d       = tag_q;
      out_valid_d = out_valid_q;
      diff_d      = diff_q;
      borrow_d    = borrow_q;
      ovf_d       = ovf_q;
      zero_d      = zero_q;
      otag_d      = otag_q;

      if (en) begin
         // Carry-in of 1 is folded into bit 0's generate so the prefix tree needs no cin.
         g_d[0]    = in_a & ~in_b;
         p_d[0]    = in_a ^ ~in_b;
         x_d[0]    = in_a ^ ~in_b;
         g_d[0][0] = g_d[0][0] | p_d[0][0];
         v_d[0]    = in_valid;
         sa_d[0]   = in_a[WIDTH-1];
         sb_d[0]   = in_b[WIDTH-1];
         tag_d[0]  = in_tag;

         // Bits below the level distance see zero from the shift and pass through.
         for (int k = 1; k <= LOG2W; k++) begin
            g_d[k]   = g_q[k-1] | (p_q[k-1] & (g_q[k-1] << (1 << (k-1))));
            x_d[k]   = x_q[k-1];
            v_d[k]   = v_q[k-1];
            sa_d[k]  = sa_q[k-1];
            sb_d[k]  = sb_q[k-1];
            tag_d[k] = tag_q[k-1];
         end
         for (int k = 1; k < LOG2W; k++) begin
            p_d[k] = p_q[k-1] & ((p_q[k-1] << (1 << (k-1))) |
                                 ~({WIDTH{1'b1}} << (1 << (k-1))));
         end

         out_valid_d = v_q[LOG2W];
         diff_d      = x_q[LOG2W] ^ {g_q[LOG2W][WIDTH-2:0], 1'b1};
         borrow_d    = ~g_q[LOG2W][WIDTH-1];
         ovf_d       = (sa_q[LOG2W] ^ sb_q[LOG2W]) & (diff_d[WIDTH-1] ^ sa_q[LOG2W]);
         zero_d      = ~|diff_d;
         otag_d      = tag_q[LOG2W];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         g_q         <= '0;
         p_q         <= '0;
         x_q         <= '0;
         v_q         <= '0;
         sa_q        <= '0;
         sb_q        <= '0;
         tag_q       <= '0;
         out_valid_q <= 1'b0;
         diff_q      <= '0;
         borrow_q    <= 1'b0;
         ovf_q       <= 1'b0;
         zero_q      <= 1'b0;
         otag_q      <= '0;
      end else begin
         g_q         <= g_d;
         p_q         <= p_d;
         x_q         <= x_d;
         v_q         <= v_d;
         sa_q        <= sa_d;
         sb_q        <= sb_d;
         tag_q       <= tag_d;
         out_valid_q <= out_valid_d;
         diff_q      <= diff_d;
         borrow_q    <= borrow_d;
         ovf_q       <= ovf_d;
         zero_q      <= zero_d;
         otag_q      <= otag_d;
      end
   end

   assign in_ready   = en;
   assign out_valid  = out_valid_q;
   assign out_diff   = diff_q;
   assign out_borrow = borrow_q;
   assign out_ovf    = ovf_q;
   assign out_zero   = zero_q;
   assign out_tag    = otag_q;

endmodule

// File: tb/tb_prefix_subtractor_pipe.sv
// Self-checking bench for prefix_subtractor_pipe: directed vector table, latency, random
// back-to-back and stalled traffic against an arithmetic reference, and mid-flight reset.
module tb_prefix_subtractor_pipe;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [4:0]  tag;
      logic [31:0] diff;
      logic        borrow;
      logic        ovf;
      logic        zero;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_a = '0;
   logic [31:0] in_b = '0;
   logic [4:0]  in_tag = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_diff;
   logic        out_borrow;
   logic        out_ovf;
   logic        out_zero;
   logic [4:0]  out_tag;

   int checks = 0;
   int failures = 0;
   int cycle_cnt = 0;
   int out_count = 0;
   int first_cyc = -1;
   int last_cyc = 0;

   vec_t expq[$];
   vec_t tbl[9];
   logic stalled_prev = 1'b0;
   logic [31:0] held_diff;
   logic [4:0]  held_tag;
   logic        held_borrow, held_ovf, held_zero;

   prefix_subtractor_pipe #(.WIDTH(32), .TAG_W(5)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_diff(out_diff), .out_borrow(out_borrow), .out_ovf(out_ovf),
      .out_zero(out_zero), .out_tag(out_tag)
   );

   always #5 clk = ~clk;

   initial begin
      #3000000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] watchdog");
   end

   // Reference: plain two's complement arithmetic in a wider signed domain.
   function automatic vec_t refModel(input logic [31:0] a, input logic [31:0] b,
                                     input logic [4:0] tag);
      vec_t   r;
      longint sd;
      sd       = longint'($signed(a)) - longint'($signed(b));
      r.a      = a;
      r.b      = b;
      r.tag    = tag;
      r.diff   = a - b;
      r.borrow = (a < b);
      r.ovf    = (sd > 64'sd2147483647) || (sd < -64'sd2147483648);
      r.zero   = (a == b);
      return r;
   endfunction

   task automatic checkOutput();
      vec_t e;
      if (rst) begin
         stalled_prev = 1'b0;
         return;
      end
      checks++;
      if (in_ready !== (!out_valid || out_ready)) begin
         failures++;
         $display("[TB] FAIL in_ready got=%b want=%b", in_ready, (!out_valid || out_ready));
      end
      if (stalled_prev) begin
         checks++;
         if (out_valid !== 1'b1 || out_diff !== held_diff || out_tag !== held_tag ||
             out_borrow !== held_borrow || out_ovf !== held_ovf || out_zero !== held_zero) begin
            failures++;
            $display("[TB] FAIL stall_hold got v=%b d=%h t=%0d want v=1 d=%h t=%0d",
                     out_valid, out_diff, out_tag, held_diff, held_tag);
         end
      end
      if (out_valid === 1'b1 && out_ready) begin
         checks++;
         if (expq.size() == 0) begin
            failures++;
            $display("[TB] FAIL spurious_output got d=%h t=%0d want none", out_diff, out_tag);
         end else begin
            e = expq.pop_front();
            if (out_diff !== e.diff || out_borrow !== e.borrow || out_ovf !== e.ovf ||
                out_zero !== e.zero || out_tag !== e.tag) begin
               failures++;
               $display("[TB] FAIL result a=%h b=%h got d=%h br=%b ov=%b z=%b t=%0d want d=%h br=%b ov=%b z=%b t=%0d",
                        e.a, e.b, out_diff, out_borrow, out_ovf, out_zero, out_tag,
                        e.diff, e.borrow, e.ovf, e.zero, e.tag);
            end
         end
         out_count++;
         if (first_cyc < 0) first_cyc = cycle_cnt;
         last_cyc = cycle_cnt;
      end
      stalled_prev = out_valid && !out_ready;
      held_diff    = out_diff;
      held_tag     = out_tag;
      held_borrow  = out_borrow;
      held_ovf     = out_ovf;
      held_zero    = out_zero;
   endtask

   task automatic applyStimulus(input logic v, input vec_t op, input logic ordy,
                                output logic accepted);
      @(negedge clk);
      in_valid  = v;
      in_a      = op.a;
      in_b      = op.b;
      in_tag    = op.tag;
      out_ready = ordy;
      #1;
      checkOutput();
      accepted = v && in_ready && !rst;
      if (accepted) expq.push_back(op);
      cycle_cnt++;
   endtask

   task automatic idle(input logic ordy);
      vec_t z;
      logic acc;
      z = refModel(32'd0, 32'd0, 5'd0);
      applyStimulus(1'b0, z, ordy, acc);
   endtask

   task automatic drain(input string name);
      for (int i = 0; i < 200 && expq.size() != 0; i++) idle(1'b1);
      checks++;
      if (expq.size() != 0) begin
         failures++;
         $display("[TB] FAIL drain_%s pending=%0d want 0", name, expq.size());
      end
   endtask

   initial begin
      vec_t op;
      logic acc;
      int   base;
      int   lat;
      int   sent;

      tbl[0] = '{32'd5,        32'd3,        5'd7,  32'd2,        1'b0, 1'b0, 1'b0};
      tbl[1] = '{32'h0,        32'h1,        5'd1,  32'hFFFFFFFF, 1'b1, 1'b0, 1'b0};
      tbl[2] = '{32'h80000000, 32'h1,        5'd2,  32'h7FFFFFFF, 1'b0, 1'b1, 1'b0};
      tbl[3] = '{32'hDEADBEEF, 32'hDEADBEEF, 5'd3,  32'h0,        1'b0, 1'b0, 1'b1};
      tbl[4] = '{32'h7FFFFFFF, 32'hFFFFFFFF, 5'd4,  32'h80000000, 1'b1, 1'b1, 1'b0};
      tbl[5] = '{32'h12345678, 32'h0,        5'd5,  32'h12345678, 1'b0, 1'b0, 1'b0};
      tbl[6] = '{32'h0,        32'h0,        5'd6,  32'h0,        1'b0, 1'b0, 1'b1};
      tbl[7] = '{32'hFFFFFFFF, 32'h1,        5'd30, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0};
      tbl[8] = '{32'h0,        32'h80000000, 5'd31, 32'h80000000, 1'b1, 1'b1, 1'b0};

      // Reset and check cleared outputs.
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      out_ready = 1'b1;
      #1;
      checks++;
      if (out_valid !== 1'b0 || out_diff !== 32'd0 || out_borrow !== 1'b0 || out_ovf !== 1'b0 ||
          out_zero !== 1'b0 || out_tag !== 5'd0 || in_ready !== 1'b1) begin
         failures++;
         $display("[TB] FAIL reset_state got v=%b d=%h br=%b ov=%b z=%b t=%0d rdy=%b want all 0, rdy=1",
                  out_valid, out_diff, out_borrow, out_ovf, out_zero, out_tag, in_ready);
      end

      $display("[TB] single op latency");
      base = out_count;
      applyStimulus(1'b1, tbl[0], 1'b1, acc);
      lat = 0;
      for (int i = 0; i < 20 && out_count == base; i++) begin
         idle(1'b1);
         lat++;
      end
      checks++;
      if (out_count != base + 1 || lat != 7) begin
         failures++;
         $display("[TB] FAIL latency got=%0d outputs=%0d want 7 cycles, 1 output", lat, out_count - base);
      end

      $display("[TB] vector table");
      for (int i = 0; i < 9; i++) applyStimulus(1'b1, tbl[i], 1'b1, acc);
      drain("table");

      $display("[TB] back-to-back random");
      base = out_count;
      first_cyc = -1;
      for (int i = 0; i < 64; i++) begin
         op = refModel($urandom, $urandom, 5'($urandom_range(0, 31)));
         applyStimulus(1'b1, op, 1'b1, acc);
      end
      drain("b2b");
      checks++;
      if (out_count - base != 64 || last_cyc - first_cyc != 63) begin
         failures++;
         $display("[TB] FAIL b2b_throughput got outputs=%0d span=%0d want 64 and 63",
                  out_count - base, last_cyc - first_cyc);
      end

      $display("[TB] random stalls");
      base = out_count;
      sent = 0;
      op = refModel($urandom, $urandom, 5'($urandom_range(0, 31)));
      for (int i = 0; i < 5000 && sent < 500; i++) begin
         applyStimulus(1'b1, op, 1'($urandom_range(0, 1)), acc);
         if (acc) begin
            sent++;
            op = refModel($urandom, $urandom, 5'($urandom_range(0, 31)));
         end
      end
      drain("stall");
      checks++;
      if (sent != 500 || out_count - base != 500) begin
         failures++;
         $display("[TB] FAIL stall_count got sent=%0d out=%0d want 500/500", sent, out_count - base);
      end

      $display("[TB] reset with ops in flight");
      for (int i = 0; i < 4; i++) begin
         op = refModel($urandom, $urandom, 5'(i + 10));
         applyStimulus(1'b1, op, 1'b0, acc);
      end
      repeat (5) idle(1'b0);
      checks++;
      if (out_valid !== 1'b1) begin
         failures++;
         $display("[TB] FAIL stalled_head got out_valid=%b want 1", out_valid);
      end
      @(negedge clk);
      rst = 1'b1;
      in_valid = 1'b0;
      out_ready = 1'b1;
      expq.delete();
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
         failures++;
         $display("[TB] FAIL reset_flush got out_valid=%b want 0", out_valid);
      end
      rst = 1'b0;
      stalled_prev = 1'b0;
      base = out_count;
      repeat (15) idle(1'b1);
      checks++;
      if (out_count != base) begin
         failures++;
         $display("[TB] FAIL ghost_results got=%0d want 0", out_count - base);
      end
      applyStimulus(1'b1, refModel(32'd100, 32'd58, 5'd21), 1'b1, acc);
      drain("post_reset");
      checks++;
      if (out_count != base + 1) begin
         failures++;
         $display("[TB] FAIL post_reset_count got=%0d want 1", out_count - base);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
